// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Forwarding and hazard unit for the 5-stage RV32 pipeline. Tracks its own
//   registered shadow of the M/W destination state, selects operand forwards
//   for the E stage, detects load-use hazards, and sequences the multi-cycle
//   divider handshake (start pulse, stall while waiting for the result).
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   Rs1D_i, Rs2D_i               D-stage source registers
//   Rs1E_i, Rs2E_i, RdE_i        E-stage source/destination registers
//   RegWriteE_i, ResultSrcE_i    E-stage control (ResultSrcE 2'b01 = load)
//   PCSrcE_i                     taken branch / jump resolved in E
//   DivE_i, DivDone_i            divide in E / divider result valid pulse
//   ForwardAE_o, ForwardBE_o     00 regfile, 01 ResultW, 10 ALUResultM
//   StallF_o, StallD_o, StallE_o pipeline-register holds
//   FlushD_o, FlushE_o           pipeline-register bubbles
//   DivGo_o                      one-cycle divider start pulse
//   StallCnt_o                   saturating count of StallF cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic                      RegWriteE_i,
    input  logic [1:0]                ResultSrcE_i,
    input  logic                      PCSrcE_i,
    input  logic                      DivE_i,
    input  logic                      DivDone_i,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      StallE_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic                      DivGo_o,
    output logic [CNT_WIDTH-1:0]      StallCnt_o
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic                      state;
    logic [REG_ADDR_WIDTH-1:0] rd_m;
    logic [REG_ADDR_WIDTH-1:0] rd_w;
    logic                      reg_write_m;
    logic                      reg_write_w;
    logic                      lw_stall;
    logic                      div_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rdm,
        input logic                      wm,
        input logic [REG_ADDR_WIDTH-1:0] rdw,
        input logic                      ww
    );
        if (wm && (rdm != '0) && (rdm == rs))
            return 2'b10;
        else if (ww && (rdw != '0) && (rdw == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Every output is gated by rst_i so the pipeline sees a clean idle
    // interface for the whole reset pulse, not just after the edge.
    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        lw_stall    = 1'b0;
        DivGo_o     = 1'b0;
        div_stall   = 1'b0;
        if (!rst_i) begin
            ForwardAE_o = fwd_sel(Rs1E_i, rd_m, reg_write_m, rd_w, reg_write_w);
            ForwardBE_o = fwd_sel(Rs2E_i, rd_m, reg_write_m, rd_w, reg_write_w);
            lw_stall    = (ResultSrcE_i == 2'b01) && RegWriteE_i && (RdE_i != '0) &&
                          ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
            DivGo_o     = (state == S_IDLE) && DivE_i;
            div_stall   = DivGo_o || ((state == S_WAIT) && !DivDone_i);
        end
    end

    // divStall dominates: a frozen E instruction is never flushed.
    assign StallF_o = div_stall || lw_stall;
    assign StallD_o = div_stall || lw_stall;
    assign StallE_o = div_stall;
    assign FlushD_o = PCSrcE_i && !div_stall && !rst_i;
    assign FlushE_o = (lw_stall || PCSrcE_i) && !div_stall && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            rd_m        <= '0;
            reg_write_m <= 1'b0;
            rd_w        <= '0;
            reg_write_w <= 1'b0;
            StallCnt_o  <= '0;
        end else begin
            // A held E instruction is sent on to M as a bubble; it advances
            // for real only in the cycle its stall is released.
            if (StallE_o) begin
                rd_m        <= '0;
                reg_write_m <= 1'b0;
            end else begin
                rd_m        <= RdE_i;
                reg_write_m <= RegWriteE_i;
            end
            rd_w        <= rd_m;
            reg_write_w <= reg_write_m;

            case (state)
                S_IDLE:  if (DivE_i)    state <= S_WAIT;
                S_WAIT:  if (DivDone_i) state <= S_IDLE;
                default:                state <= S_IDLE;
            endcase

            if (StallF_o && (StallCnt_o != '1))
                StallCnt_o <= StallCnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs1d = '0, rs2d = '0, rs1e = '0, rs2e = '0, rde = '0;
    logic          rwe = 1'b0;
    logic [1:0]    rse = 2'b00;
    logic          pcs = 1'b0, dive = 1'b0, done = 1'b0;
    logic [1:0]    fa, fb;
    logic          sf, sd, se, fd, fe, go;
    logic [CW-1:0] cnt;

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e), .RdE_i(rde),
        .RegWriteE_i(rwe), .ResultSrcE_i(rse), .PCSrcE_i(pcs),
        .DivE_i(dive), .DivDone_i(done),
        .ForwardAE_o(fa), .ForwardBE_o(fb),
        .StallF_o(sf), .StallD_o(sd), .StallE_o(se),
        .FlushD_o(fd), .FlushE_o(fe), .DivGo_o(go), .StallCnt_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [12:0] exp;   // {fa, fb, sf, sd, se, fd, fe, go, cnt}
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Monitor: combinational outputs are sampled mid-cycle, away from posedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [12:0] act;
            it  = q.pop_front();
            act = {fa, fb, sf, sd, se, fd, fe, go, cnt};
            n_checks++;
            if (act === it.exp)
                n_pass++;
            else
                $display("FAIL vec%0d: got fa=%b fb=%b sf/sd/se/fd/fe/go=%b cnt=%0d, required fa=%b fb=%b sf/sd/se/fd/fe/go=%b cnt=%0d",
                         it.id, act[12:11], act[10:9], act[8:3], act[2:0],
                         it.exp[12:11], it.exp[10:9], it.exp[8:3], it.exp[2:0]);
        end
    end

    int vid = 0;

    task automatic vec(input logic r,
                       input logic [4:0] i_rs1d, input logic [4:0] i_rs2d,
                       input logic [4:0] i_rs1e, input logic [4:0] i_rs2e,
                       input logic [4:0] i_rde, input logic i_rwe, input logic [1:0] i_rse,
                       input logic i_pcs, input logic i_dive, input logic i_done,
                       input logic [1:0] e_fa, input logic [1:0] e_fb,
                       input logic [5:0] e_ctl, input logic [CW-1:0] e_cnt);
        item_t it;
        @(posedge clk);
        #1;
        rst = r; rs1d = i_rs1d; rs2d = i_rs2d; rs1e = i_rs1e; rs2e = i_rs2e;
        rde = i_rde; rwe = i_rwe; rse = i_rse; pcs = i_pcs; dive = i_dive; done = i_done;
        it.id  = vid;
        it.exp = {e_fa, e_fb, e_ctl, e_cnt};
        q.push_back(it);
        vid++;
    endtask

    initial begin
        //   rst rs1d rs2d rs1e rs2e rde rwe rse  pcs div done | fa fb  sf sd se fd fe go  cnt
        // Reset forces everything quiet even with DivE/PCSrcE asserted
        vec(1, 0, 0, 5, 0, 5, 1, 2'b00, 1, 1, 0,  2'b00, 2'b00, 6'b000000, 0);
        // ALU forwarding chain
        vec(0, 0, 0, 1, 2, 5, 1, 2'b00, 0, 0, 0,  2'b00, 2'b00, 6'b000000, 0);
        vec(0, 0, 0, 5, 6, 6, 1, 2'b00, 0, 0, 0,  2'b10, 2'b00, 6'b000000, 0);
        vec(0, 0, 0, 0, 5, 0, 1, 2'b00, 0, 0, 0,  2'b00, 2'b01, 6'b000000, 0);
        // x0 written in M: reader of x0 must not forward
        vec(0, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0,  2'b00, 2'b00, 6'b000000, 0);
        vec(0, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0,  2'b00, 2'b00, 6'b000000, 0);
        // M over W priority (RdM = RdW = 7)
        vec(0, 0, 0, 7, 7, 0, 0, 2'b00, 0, 0, 0,  2'b10, 2'b10, 6'b000000, 0);
        // Load-use: lw x3 in E, Rs2D = 3
        vec(0, 0, 3, 7, 0, 3, 1, 2'b01, 0, 0, 0,  2'b01, 2'b00, 6'b110010, 0);
        vec(0, 0, 3, 0, 0, 0, 0, 2'b00, 0, 0, 0,  2'b00, 2'b00, 6'b000000, 1);
        vec(0, 0, 0, 0, 3, 4, 1, 2'b00, 0, 0, 0,  2'b00, 2'b01, 6'b000000, 1);
        // Branch taken, no load
        vec(0, 0, 0, 4, 0, 0, 0, 2'b00, 1, 0, 0,  2'b10, 2'b00, 6'b000110, 1);
        // Branch taken together with load-use
        vec(0, 9, 0, 4, 0, 9, 1, 2'b01, 1, 0, 0,  2'b01, 2'b00, 6'b110110, 1);
        // Divide: go in cycle 0, wait 1..3 (branch in WAIT is not flushed), done in cycle 4
        vec(0, 0, 0, 9, 0, 10, 1, 2'b00, 0, 1, 0, 2'b10, 2'b00, 6'b111001, 2);
        vec(0, 0, 0, 9, 0, 10, 1, 2'b00, 1, 1, 0, 2'b01, 2'b00, 6'b111000, 3);
        vec(0, 0, 0, 9, 0, 10, 1, 2'b00, 0, 1, 0, 2'b00, 2'b00, 6'b111000, 4);
        vec(0, 0, 0, 9, 0, 10, 1, 2'b00, 0, 1, 0, 2'b00, 2'b00, 6'b111000, 5);
        vec(0, 0, 0, 9, 0, 10, 1, 2'b00, 0, 1, 1, 2'b00, 2'b00, 6'b000000, 6);
        // New divide from IDLE; its rd reached M only after done
        vec(0, 0, 0, 10, 0, 11, 1, 2'b00, 0, 1, 0, 2'b10, 2'b00, 6'b111001, 6);
        // Done cycle with load-use still stalls; counter saturates at 7
        vec(0, 11, 0, 10, 0, 11, 1, 2'b01, 0, 1, 1, 2'b01, 2'b00, 6'b110010, 7);
        vec(0, 0, 0, 11, 0, 12, 1, 2'b00, 0, 1, 0, 2'b10, 2'b00, 6'b111001, 7);
        vec(0, 0, 0, 11, 0, 12, 1, 2'b00, 0, 1, 0, 2'b01, 2'b00, 6'b111000, 7);
        // Reset asserted while in WAIT: quiet outputs and cleared counter before any edge
        vec(1, 0, 0, 11, 0, 12, 1, 2'b00, 0, 1, 0, 2'b00, 2'b00, 6'b000000, 0);
        // Back in IDLE with cleared shadows
        vec(0, 0, 0, 11, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 6'b000000, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: got %0d unchecked vectors, required 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
